// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-0 SPI master serialising a byte stream MSB first
// cs_n stays low across bytes until a byte flagged last has been shifted.
module spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  localparam int M_A     = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int M_B     = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int CNT_MAX = (M_A > M_B) ? M_A : M_B;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] LD_DIV   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LD_SETUP = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] LD_IDLE  = CW'(CS_IDLE - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_LOW   = 3'd2;
  localparam logic [2:0] S_HIGH  = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;
  localparam logic [2:0] S_GAP   = 3'd6;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [6:0]    tx_sr;   // bit 7 goes straight to mosi on accept
  logic [7:0]    rx_sr;
  logic          last_q;

  assign tx_ready = (state == S_IDLE) || (state == S_NEXT);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_cnt  <= 3'd0;
      tx_sr    <= 7'd0;
      rx_sr    <= 8'd0;
      last_q   <= 1'b0;
      rx_data  <= 8'd0;
      rx_valid <= 1'b0;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_valid) begin
            tx_sr   <= tx_data[6:0];
            last_q  <= tx_last;
            mosi    <= tx_data[7];
            cs_n    <= 1'b0;
            bit_cnt <= 3'd0;
            cnt     <= LD_SETUP;
            state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == '0) begin
            cnt   <= LD_DIV;
            state <= S_LOW;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_LOW: begin
          if (cnt == '0) begin
            sclk  <= 1'b1;
            rx_sr <= {rx_sr[6:0], miso};
            cnt   <= LD_DIV;
            state <= S_HIGH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_HIGH: begin
          if (cnt == '0) begin
            sclk <= 1'b0;
            if (bit_cnt == 3'd7) begin
              rx_data  <= rx_sr;
              rx_valid <= 1'b1;
              bit_cnt  <= 3'd0;
              cnt      <= LD_HOLD;
              state    <= last_q ? S_HOLD : S_NEXT;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              mosi    <= tx_sr[6];
              tx_sr   <= {tx_sr[5:0], 1'b0};
              cnt     <= LD_DIV;
              state   <= S_LOW;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_NEXT: begin
          // chip select already asserted, so go straight into the low half
          if (tx_valid) begin
            tx_sr   <= tx_data[6:0];
            last_q  <= tx_last;
            mosi    <= tx_data[7];
            bit_cnt <= 3'd0;
            cnt     <= LD_DIV;
            state   <= S_LOW;
          end
        end
        S_HOLD: begin
          if (cnt == '0) begin
            cs_n  <= 1'b1;
            mosi  <= 1'b0;
            cnt   <= LD_IDLE;
            state <= S_GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed bench for spi_master with a behavioural mode-0 slave
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'd0;
  logic       tx_last = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;

  spi_master #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(4)) dut (
    .clk(clk), .rst(rst),
    .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  // Slave shifts its reply out on SCLK falls; reloads on cs_n fall and after each byte.
  logic [7:0] slave_reply [2];
  logic [7:0] slave_sr = 8'd0;
  logic       tie_one = 1'b0;
  int         s_bit = 0;
  int         s_idx = 0;

  always @(negedge cs_n) begin
    s_bit = 0;
    s_idx = 0;
    slave_sr = slave_reply[0];
  end

  always @(negedge sclk) begin
    if (!cs_n) begin
      s_bit++;
      if (s_bit == 8) begin
        s_bit = 0;
        s_idx++;
        slave_sr = slave_reply[s_idx % 2];
      end else begin
        slave_sr = {slave_sr[6:0], 1'b0};
      end
    end
  end

  assign miso = tie_one | slave_sr[7];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic        sclk_h [400];
  logic        cs_h   [400];
  logic        mosi_h [400];
  logic        rdy_h  [400];
  logic        busy_h [400];
  int          rise_e [32];
  int          fall_e [32];
  int          rxv_e  [8];
  logic [7:0]  rxv_d  [8];
  int          acc_e  [4];
  logic [7:0]  txb    [4];
  logic        txl    [4];
  int          nr, nf, nv, nb, idx, stall_len;
  logic [31:0] mosi_bits;

  // Edge 0 is the first posedge after the call; history[e] is the state just after edge e.
  task automatic run(input int n);
    int   stall;
    logic will;
    logic prev_sclk;
    nr = 0; nf = 0; nv = 0; idx = 0; stall = 0;
    mosi_bits = 32'd0;
    prev_sclk = sclk;
    tx_data  = txb[0];
    tx_last  = txl[0];
    tx_valid = 1'b1;
    will     = tx_ready;
    for (int e = 0; e < n; e++) begin
      @(negedge clk);
      if (will) begin
        acc_e[idx] = e;
        idx++;
        if (idx < nb) begin
          tx_data  = txb[idx];
          tx_last  = txl[idx];
          tx_valid = (stall_len == 0);
          stall    = stall_len;
        end else begin
          tx_valid = 1'b0;
        end
      end else if (stall > 0 && tx_ready) begin
        stall--;
        if (stall == 0) tx_valid = 1'b1;
      end
      sclk_h[e] = sclk;
      cs_h[e]   = cs_n;
      mosi_h[e] = mosi;
      rdy_h[e]  = tx_ready;
      busy_h[e] = busy;
      if (sclk && !prev_sclk) begin
        rise_e[nr] = e;
        nr++;
        mosi_bits = {mosi_bits[30:0], mosi};
      end
      if (!sclk && prev_sclk) begin
        fall_e[nf] = e;
        nf++;
      end
      if (rx_valid) begin
        rxv_e[nv] = e;
        rxv_d[nv] = rx_data;
        nv++;
      end
      prev_sclk = sclk;
      will = tx_valid && tx_ready;
    end
  endtask

  function automatic int first_cs_high(input int n);
    int t;
    t = -1;
    for (int e = 0; e < n; e++)
      if (cs_h[e] && t < 0) t = e;
    return t;
  endfunction

  initial begin
    int bad;
    slave_reply[0] = 8'h00;
    slave_reply[1] = 8'h00;

    // reset state
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);

    // single byte
    txb[0] = 8'hA5; txl[0] = 1'b1; nb = 1; stall_len = 0;
    slave_reply[0] = 8'h3C; slave_reply[1] = 8'h3C;
    run(80);
    check("single_accepts", 32'(idx), 32'd1);
    check("single_rises", 32'(nr), 32'd8);
    for (int k = 0; k < 8; k++)
      check($sformatf("single_rise%0d", k), 32'(rise_e[k]), 32'(6 + 8 * k));
    check("single_fall8", 32'(fall_e[7]), 32'd66);
    check("single_mosi", 32'(mosi_bits[7:0]), 32'hA5);
    check("single_rxv_cnt", 32'(nv), 32'd1);
    check("single_rxv_edge", 32'(rxv_e[0]), 32'd66);
    check("single_rx_data", 32'(rxv_d[0]), 32'h3C);
    check("single_cs_rise", 32'(first_cs_high(80)), 32'd68);
    check("single_ready71", 32'(rdy_h[71]), 32'd0);
    check("single_ready72", 32'(rdy_h[72]), 32'd1);
    check("single_busy72", 32'(busy_h[72]), 32'd0);
    check("single_rx_held", 32'(rx_data), 32'h3C);

    // back-to-back
    txb[0] = 8'h12; txl[0] = 1'b0; txb[1] = 8'h34; txl[1] = 1'b1; nb = 2; stall_len = 0;
    slave_reply[0] = 8'hC3; slave_reply[1] = 8'h81;
    run(145);
    check("b2b_accepts", 32'(idx), 32'd2);
    check("b2b_accept2", 32'(acc_e[1]), 32'd67);
    check("b2b_rise9", 32'(rise_e[8]), 32'd71);
    check("b2b_rises", 32'(nr), 32'd16);
    check("b2b_mosi", 32'(mosi_bits[15:0]), 32'h1234);
    check("b2b_rxv_cnt", 32'(nv), 32'd2);
    check("b2b_rxv_edge2", 32'(rxv_e[1]), 32'd131);
    check("b2b_rx0", 32'(rxv_d[0]), 32'hC3);
    check("b2b_rx1", 32'(rxv_d[1]), 32'h81);
    check("b2b_cs_rise", 32'(first_cs_high(145)), 32'd133);

    // stall in NEXT
    txb[0] = 8'h12; txl[0] = 1'b0; txb[1] = 8'h34; txl[1] = 1'b1; nb = 2; stall_len = 20;
    slave_reply[0] = 8'h0F; slave_reply[1] = 8'hF0;
    run(160);
    bad = 0;
    for (int e = 66; e < 86; e++)
      if (sclk_h[e] !== 1'b0 || cs_h[e] !== 1'b0 || busy_h[e] !== 1'b1) bad++;
    check("stall_idle_lines", 32'(bad), 32'd0);
    check("stall_accept2", 32'(acc_e[1]), 32'd86);
    check("stall_rise9", 32'(rise_e[8]), 32'd90);
    check("stall_rises", 32'(nr), 32'd16);
    check("stall_mosi", 32'(mosi_bits[15:0]), 32'h1234);
    check("stall_rxv_cnt", 32'(nv), 32'd2);
    check("stall_rx0", 32'(rxv_d[0]), 32'h0F);
    check("stall_rx1", 32'(rxv_d[1]), 32'hF0);

    // valid held through GAP is ignored until IDLE
    txb[0] = 8'h81; txl[0] = 1'b1; txb[1] = 8'h77; txl[1] = 1'b1; nb = 2; stall_len = 0;
    slave_reply[0] = 8'h55; slave_reply[1] = 8'h55;
    run(150);
    check("gap_cs_high", 32'(cs_h[70]), 32'd1);
    check("gap_accept2", 32'(acc_e[1]), 32'd73);
    check("gap_accepts", 32'(idx), 32'd2);
    check("gap_rises", 32'(nr), 32'd16);
    check("gap_mosi", 32'(mosi_bits[15:0]), 32'h8177);
    check("gap_rx1", 32'(rxv_d[1]), 32'h55);

    // reset during the third bit
    txb[0] = 8'hC3; txl[0] = 1'b1; nb = 1; stall_len = 0;
    slave_reply[0] = 8'hFF; slave_reply[1] = 8'hFF;
    run(24);
    check("midrst_sclk_before", 32'(sclk), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_cs_n", 32'(cs_n), 32'd1);
    check("midrst_sclk", 32'(sclk), 32'd0);
    check("midrst_mosi", 32'(mosi), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rx_data", 32'(rx_data), 32'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = nv;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rx_valid) bad++;
    end
    check("midrst_no_rxv", 32'(bad), 32'd0);
    txb[0] = 8'h5A; txl[0] = 1'b1; nb = 1;
    slave_reply[0] = 8'h99; slave_reply[1] = 8'h99;
    run(80);
    check("post_rises", 32'(nr), 32'd8);
    check("post_mosi", 32'(mosi_bits[7:0]), 32'h5A);
    check("post_rx", 32'(rxv_d[0]), 32'h99);

    // miso tied high, all-zero byte out
    tie_one = 1'b1;
    txb[0] = 8'h00; txl[0] = 1'b1; nb = 1;
    run(80);
    bad = 0;
    for (int e = 0; e < 80; e++)
      if (mosi_h[e] !== 1'b0) bad++;
    check("ones_rx", 32'(rxv_d[0]), 32'hFF);
    check("ones_mosi_low", 32'(bad), 32'd0);
    check("ones_mosi_bits", 32'(mosi_bits[7:0]), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Mode-0 SPI master that drives one external or on-chip SPI slave from the peripheral clock domain. It serialises bytes from a valid/ready byte stream onto `mosi`, MSB first. It captures `miso` into received bytes and holds `cs_n` low across a multi-byte transaction until a byte marked last completes. It is the initiator side of the same SPI link served by the PWM block's SPI slave bridge, and is used by test harnesses and by the host-side subsystem.

## Interface
- `CLK_DIV`, 4: `clk` cycles per SCLK half-period. Must be ≥4 so a 2-FF-synchronising slave sees every edge.
- `CS_SETUP`, 2: `clk` cycles from `cs_n` fall to the start of the first SCLK low half-period. Must be ≥1.
- `CS_HOLD`, 2: `clk` cycles from the last SCLK fall to `cs_n` rise. Must be ≥1.
- `CS_IDLE`, 4: minimum `clk` cycles `cs_n` stays high between transactions. Must be ≥1.
- `clk` in 1: peripheral clock. Single clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `tx_data` in 8: byte to send.
- `tx_last` in 1: with `tx_data`; 1 means this byte ends the transaction.
- `tx_valid` in 1: `tx_data`/`tx_last` valid.
- `tx_ready` out 1: byte accepted on a `clk` edge where `tx_valid & tx_ready`.
- `rx_data` out 8: last received byte. Held until the next byte completes.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `busy` out 1: high whenever the state is not IDLE.
- `sclk` out 1: SPI clock. Idles low (CPOL=0).
- `cs_n` out 1: chip select, active-low.
- `mosi` out 1: serial data out.
- `miso` in 1: serial data in. Sampled directly with no synchroniser; the slave is timed by this master.

## Operation
- States: IDLE, SETUP, LOW, HIGH, NEXT, HOLD, GAP. A single down-counter is sized for max(`CLK_DIV`, `CS_SETUP`, `CS_HOLD`, `CS_IDLE`). A 3-bit bit counter tracks bits within a byte.
- **Reset** (asynchronous, immediate, even mid-byte):
  - State IDLE, `cs_n`=1, `sclk`=0, `mosi`=0.
  - `rx_data`=0x00, `rx_valid`=0, `busy`=0, counters 0.
  - No partial byte is reported.
- **IDLE:**
  - `tx_ready`=1.
  - On accept: load the TX shift register with `tx_data`, latch `tx_last`, set `cs_n`=0, drive `mosi`=`tx_data[7]`, and go to SETUP.
- **SETUP:** wait `CS_SETUP` cycles, then go to LOW.
- **LOW:**
  - Hold `sclk`=0 for `CLK_DIV` cycles.
  - On exit, drive `sclk`=1, shift `miso` into the RX shift register (LSB in), and go to HIGH.
- **HIGH:** hold `sclk`=1 for `CLK_DIV` cycles. On exit, drive `sclk`=0, then:
  - If fewer than 8 bits are done: shift TX left, drive `mosi`= next bit, go to LOW.
  - After the 8th bit: set `rx_data`= the assembled byte and pulse `rx_valid`. Go to HOLD if the latched last flag is 1, else NEXT.
- **NEXT:**
  - `cs_n` stays 0, `sclk` stays 0, `tx_ready`=1.
  - Stalls indefinitely while `tx_valid`=0.
  - On accept: load TX, latch `tx_last`, drive `mosi`=`tx_data[7]`, go to LOW with the counter reloaded. SETUP is not repeated.
- **HOLD:** wait `CS_HOLD` cycles. On exit, drive `cs_n`=1, `mosi`=0, and go to GAP.
- **GAP:** wait `CS_IDLE` cycles, then go to IDLE.
- `tx_ready`=0 in SETUP, LOW, HIGH, HOLD and GAP. `tx_valid` in those states is ignored and must be held by the source.
- Bits are sent and received MSB first. `mosi` changes only on the `clk` edge where `sclk` falls, or on byte accept. It is therefore stable across every SCLK rise.

## Timing
- Take the IDLE accept edge as edge 0.
  - First `sclk` rise is at edge `CS_SETUP`+`CLK_DIV`.
  - Rise k (k=0..7) is at that edge + 2·`CLK_DIV`·k. Each fall follows its rise by `CLK_DIV`.
  - `rx_valid` is high for the one cycle after the 8th-fall edge.
  - `cs_n` rises `CS_HOLD` edges after the 8th fall.
  - IDLE (`tx_ready`=1) is reached `CS_IDLE` edges after `cs_n` rises.
- Byte accepted in NEXT at edge n: next `sclk` rise is at edge n+`CLK_DIV`.
- `rx_valid` never asserts for two consecutive cycles.

## Test plan
Settings for all scenarios: `CLK_DIV`=4, `CS_SETUP`=2, `CS_HOLD`=2, `CS_IDLE`=4. The bench uses a behavioural mode-0 slave.

- **Single byte:** send 0xA5 with last=1; slave returns 0x3C.
  - `mosi` at the rises is 1,0,1,0,0,1,0,1. Rises occur at edges 6,14,…,62 and the 8th fall at 66.
  - `rx_valid` one cycle with `rx_data`=0x3C.
  - `cs_n` low from edge 0 to edge 68. `tx_ready` returns at edge 72.
- **Back-to-back:** send 0x12 (last=0) then 0x34 (last=1) with `tx_valid` held.
  - `cs_n` stays low for 16 SCLK pulses.
  - Second byte accepted one cycle after the 8th fall; its first rise follows 4 cycles later.
  - Two `rx_valid` pulses occur.
- **Stall:** after 0x12 (last=0), hold `tx_valid`=0 for 20 cycles.
  - `sclk`=0, `cs_n`=0, `busy`=1 throughout.
  - Then 0x34 (last=1) completes normally.
- **Reset mid-byte:** assert `rst` during the 3rd bit.
  - `cs_n`=1, `sclk`=0, `mosi`=0 with no `clk` edge needed.
  - No `rx_valid` pulse.
  - A following 0x5A transfer is bit-exact.
- **Ignored valid:** hold `tx_valid` with 0x77 during GAP.
  - No accept until IDLE; then exactly one transfer of 0x77 occurs.
- **All-ones input:** tie `miso`=1 and send 0x00 (last=1).
  - `rx_data`=0xFF and `mosi` stays 0.
